// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state encoding and tag helper for the ALU sequencer.
package alu_pkg;

   localparam int OP_W  = 4;
   localparam int TAG_W = 4;

   localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
   localparam logic [OP_W-1:0] ALU_SUB = 4'h1;
   localparam logic [OP_W-1:0] ALU_AND = 4'h2;
   localparam logic [OP_W-1:0] ALU_OR  = 4'h3;
   localparam logic [OP_W-1:0] ALU_XOR = 4'h4;
   localparam logic [OP_W-1:0] ALU_MUL = 4'h5;
   localparam logic [OP_W-1:0] ALU_DIV = 4'h6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } seq_state_e;

   // Tags are a free-running sequence number that wraps 15 -> 0.
   function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
      return t + 1'b1;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a command producer and the ALU sequencer.
interface alu_sequencer_if #(
   parameter int WIDTH = 16
) ();
   import alu_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [WIDTH-1:0]  cmd_a;
   logic [WIDTH-1:0]  cmd_b;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_result;
   logic [WIDTH-1:0]  rsp_remainder;
   logic              rsp_zero;
   logic [TAG_W-1:0]  rsp_tag;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_zero, rsp_tag
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_zero, rsp_tag
   );

endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: add/sub/and/or/xor, multiply (high word on remainder) and unsigned divide.
module alu_sequencer_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             zero
);

   logic [2*WIDTH-1:0] prod;

   always_comb begin
      prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      result    = '0;
      remainder = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_MUL: begin
            result    = prod[WIDTH-1:0];
            remainder = prod[2*WIDTH-1:WIDTH];
         end
         ALU_DIV: begin
            // Divide by zero saturates the quotient and returns the dividend.
            if (b == '0) begin
               result    = '1;
               remainder = a;
            end else begin
               result    = a / b;
               remainder = a % b;
            end
         end
         default: begin
            result    = '0;
            remainder = '0;
         end
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands in a small FIFO and runs them one at a time through an
// IDLE -> EXEC -> RESP sequence, returning tagged results in acceptance order.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_sequencer_if.slave  bus,
   output logic            busy
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   cmd_t             mem_q [DEPTH];
   cmd_t             mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;

   seq_state_e       state_q, state_d;
   cmd_t             opnd_q, opnd_d;

   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;

   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] alu_remainder;
   logic             alu_zero;

   alu_sequencer_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .op        (opnd_q.op),
      .a         (opnd_q.a),
      .b         (opnd_q.b),
      .result    (alu_result),
      .remainder (alu_remainder),
      .zero      (alu_zero)
   );

   // Ready is derived from the registered count, so a pop from a full FIFO
   // only re-opens the input on the cycle after the pop edge.
   always_comb begin
      fifo_empty    = (count_q == '0);
      fifo_full     = (count_q == (AW+1)'(DEPTH));
      bus.cmd_ready = rst_n & ~fifo_full;
      push          = bus.cmd_valid & bus.cmd_ready;
      pop           = (state_q == ST_IDLE) & ~fifo_empty;
   end

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      tag_cnt_d = tag_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: tag_cnt_q};
         wr_ptr_d        = wr_ptr_q + 1'b1;
         tag_cnt_d       = next_tag(tag_cnt_q);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      opnd_d          = opnd_q;
      rsp_result_d    = rsp_result_q;
      rsp_remainder_d = rsp_remainder_q;
      rsp_zero_d      = rsp_zero_q;
      rsp_tag_d       = rsp_tag_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               opnd_d  = mem_q[rd_ptr_q];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_result_d    = alu_result;
            rsp_remainder_d = alu_remainder;
            rsp_zero_d      = alu_zero;
            rsp_tag_d       = opnd_q.tag;
            state_d         = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.rsp_valid     = (state_q == ST_RESP);
      bus.rsp_result    = rsp_result_q;
      bus.rsp_remainder = rsp_remainder_q;
      bus.rsp_zero      = rsp_zero_q;
      bus.rsp_tag       = rsp_tag_q;
      busy              = (state_q != ST_IDLE) | ~fifo_empty;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         tag_cnt_q       <= '0;
         state_q         <= ST_IDLE;
         opnd_q          <= '0;
         rsp_result_q    <= '0;
         rsp_remainder_q <= '0;
         rsp_zero_q      <= 1'b0;
         rsp_tag_q       <= '0;
      end else begin
         mem_q           <= mem_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         tag_cnt_q       <= tag_cnt_d;
         state_q         <= state_d;
         opnd_q          <= opnd_d;
         rsp_result_q    <= rsp_result_d;
         rsp_remainder_q <= rsp_remainder_d;
         rsp_zero_q      <= rsp_zero_d;
         rsp_tag_q       <= rsp_tag_d;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer: reset, latency, ordering, backpressure,
// flag boundaries, tag wrap and mid-operation reset.
module tb_alu_sequencer;

   typedef struct {
      logic [15:0] res;
      logic [15:0] rem;
      logic        zero;
      logic [3:0]  tag;
   } exp_t;

   logic clk;
   logic rst_n;
   logic busy;
   int   vecs;
   int   errs;
   exp_t exp_q[$];

   alu_sequencer_if #(.WIDTH(16)) bus ();

   alu_sequencer #(
      .WIDTH(16),
      .DEPTH(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      vecs++;
      assert (obs === expv)
      else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // Handshake completes on the edge following a sample with cmd_ready high.
   task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int waited;
      waited        = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      while (!bus.cmd_ready && waited < 100) begin
         step();
         waited++;
      end
      if (!bus.cmd_ready) begin
         chk("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
      end else begin
         step();
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int waited;
      waited = 0;
      while (!bus.rsp_valid && waited < 100) begin
         step();
         waited++;
      end
      if (!bus.rsp_valid) chk("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
   endtask

   task automatic run_one(input string name, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic [15:0] rem,
                          input logic zero, input logic [3:0] tag);
      push(op, a, b);
      wait_rsp();
      chk({name, "_result"}, 32'(bus.rsp_result), 32'(res));
      chk({name, "_remainder"}, 32'(bus.rsp_remainder), 32'(rem));
      chk({name, "_zero"}, 32'(bus.rsp_zero), 32'(zero));
      chk({name, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   // Drains exp_q with rsp_ready held high; successive responses must be 3 cycles apart.
   task automatic collect(input string name, input int n);
      int   got;
      int   cyc;
      int   last;
      exp_t e;
      got  = 0;
      cyc  = 0;
      last = -1;
      while (got < n && cyc < 300) begin
         if (bus.rsp_valid) begin
            e = exp_q.pop_front();
            chk({name, "_result"}, 32'(bus.rsp_result), 32'(e.res));
            chk({name, "_zero"}, 32'(bus.rsp_zero), 32'(e.zero));
            chk({name, "_tag"}, 32'(bus.rsp_tag), 32'(e.tag));
            if (last >= 0) chk({name, "_gap"}, 32'(cyc - last), 32'd3);
            last = cyc;
            got++;
         end
         step();
         cyc++;
      end
      chk({name, "_count"}, 32'(got), 32'(n));
   endtask

   initial begin
      int seen;
      vecs = 0;
      errs = 0;

      // Reset state
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) step();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
      chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
      chk("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // Single add: response visible after the second edge following acceptance
      push(4'h0, 16'd15, 16'd10);
      chk("lat_k1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("lat_k1_busy", 32'(busy), 32'd1);
      step();
      chk("lat_k2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      step();
      chk("lat_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("lat_result", 32'(bus.rsp_result), 32'd25);
      chk("lat_zero", 32'(bus.rsp_zero), 32'd0);
      chk("lat_tag", 32'(bus.rsp_tag), 32'd0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("lat_consumed", 32'(bus.rsp_valid), 32'd0);
      chk("lat_idle_busy", 32'(busy), 32'd0);

      // Back-to-back sub/and/or with rsp_ready held high
      do_reset();
      bus.rsp_ready = 1'b1;
      exp_q.push_back('{res: 16'd10, rem: 16'd0, zero: 1'b0, tag: 4'd0});
      exp_q.push_back('{res: 16'd8,  rem: 16'd0, zero: 1'b0, tag: 4'd1});
      exp_q.push_back('{res: 16'd14, rem: 16'd0, zero: 1'b0, tag: 4'd2});
      push(4'h1, 16'd20, 16'd10);
      push(4'h2, 16'd12, 16'd10);
      push(4'h3, 16'd12, 16'd10);
      collect("b2b", 3);
      bus.rsp_ready = 1'b0;

      // Backpressure: 4 queued plus 1 held in the response registers
      do_reset();
      push(4'h0, 16'd1, 16'd2);
      push(4'h1, 16'd10, 16'd3);
      push(4'h2, 16'hF0F0, 16'hFF00);
      push(4'h3, 16'h000F, 16'h00F0);
      push(4'h0, 16'd100, 16'd200);
      chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("full_head_result", 32'(bus.rsp_result), 32'd3);
      chk("full_head_tag", 32'(bus.rsp_tag), 32'd0);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 4'h0;
      bus.cmd_a     = 16'hDEAD;
      bus.cmd_b     = 16'hBEEF;
      repeat (3) step();
      bus.cmd_valid = 1'b0;
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_result", 32'(bus.rsp_result), 32'd3);
      chk("hold_tag", 32'(bus.rsp_tag), 32'd0);
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      bus.rsp_ready = 1'b1;
      step();
      chk("pop_edge_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      step();
      chk("after_pop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      exp_q.push_back('{res: 16'd7,     rem: 16'd0, zero: 1'b0, tag: 4'd1});
      exp_q.push_back('{res: 16'hF000,  rem: 16'd0, zero: 1'b0, tag: 4'd2});
      exp_q.push_back('{res: 16'h00FF,  rem: 16'd0, zero: 1'b0, tag: 4'd3});
      exp_q.push_back('{res: 16'd300,   rem: 16'd0, zero: 1'b0, tag: 4'd4});
      collect("drain", 4);
      bus.rsp_ready = 1'b0;

      // Zero flag and wrap boundaries, plus forwarded opcodes
      do_reset();
      run_one("add00",   4'h0, 16'd0,     16'd0,     16'd0,     16'd0,  1'b1, 4'd0);
      run_one("addwrap", 4'h0, 16'hFFFF,  16'd1,     16'd0,     16'd0,  1'b1, 4'd1);
      run_one("subwrap", 4'h1, 16'd0,     16'd1,     16'hFFFF,  16'd0,  1'b0, 4'd2);
      run_one("xor",     4'h4, 16'h00FF,  16'h0F0F,  16'h0FF0,  16'd0,  1'b0, 4'd3);
      run_one("mul",     4'h5, 16'h0100,  16'h0300,  16'h0000,  16'h3,  1'b1, 4'd4);
      run_one("div",     4'h6, 16'd100,   16'd7,     16'd14,    16'd2,  1'b0, 4'd5);
      run_one("div0",    4'h6, 16'd5,     16'd0,     16'hFFFF,  16'd5,  1'b0, 4'd6);
      run_one("undef",   4'hF, 16'd9,     16'd9,     16'd0,     16'd0,  1'b1, 4'd7);

      // Tag wraps 15 -> 0
      do_reset();
      for (int i = 0; i < 17; i++) begin
         run_one("tagwrap", 4'h0, 16'(i), 16'd1, 16'(i + 1), 16'd0, 1'b0, 4'(i));
      end

      // Reset asserted while EXEC is active with two commands still queued
      do_reset();
      push(4'h0, 16'd1, 16'd1);
      push(4'h0, 16'd2, 16'd2);
      push(4'h0, 16'd3, 16'd3);
      push(4'h0, 16'd4, 16'd4);
      chk("mid_head_valid", 32'(bus.rsp_valid), 32'd1);
      chk("mid_head_result", 32'(bus.rsp_result), 32'd2);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      step();
      chk("mid_exec_busy", 32'(busy), 32'd1);
      chk("mid_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("mid_rst_result", 32'(bus.rsp_result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      bus.rsp_ready = 1'b1;
      repeat (10) begin
         step();
         if (bus.rsp_valid) seen++;
      end
      bus.rsp_ready = 1'b0;
      chk("mid_no_rsp", 32'(seen), 32'd0);
      chk("mid_idle_busy", 32'(busy), 32'd0);
      run_one("mid_next", 4'h0, 16'd3, 16'd4, 16'd7, 16'd0, 1'b0, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter DEPTH, default 4, command FIFO entries, power of two, minimum 2.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-007 cmd_op  input  4  ALU operation code.
REQ-008 cmd_a, cmd_b  input  WIDTH each  operands.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_result, rsp_remainder  output  WIDTH each  captured ALU result and remainder.
REQ-012 rsp_zero  output  1  captured ALU zero flag.
REQ-013 rsp_tag  output  4  sequence tag of the command producing this response.
REQ-014 busy  output  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-015 Command handshake SHALL complete on a rising edge where cmd_valid and cmd_ready are both high; cmd_ready = FIFO not full, independent of cmd_valid.
REQ-016 Each accepted command SHALL be stored in FIFO with {op, a, b, tag}; tag = internal 4-bit counter, incremented per accepted command, wrapping 15 -> 0.
REQ-017 FSM states: IDLE, EXEC, RESP.
REQ-018 IDLE: FIFO non-empty -> pop head into operand registers driving ALU inputs, go EXEC; else stay.
REQ-019 EXEC: register ALU result, remainder, zero and operand tag into response registers, go RESP (one cycle, unconditional).
REQ-020 RESP: rsp_valid = 1; rsp_ready high -> go IDLE; else hold all rsp_* stable.
REQ-021 Latency: command accepted at edge k into an empty FIFO with FSM in IDLE SHALL give rsp_valid high after edge k+2.
REQ-022 Peak throughput: one response per 3 cycles with rsp_ready held high.
REQ-023 Push and pop on the same edge SHALL leave FIFO occupancy unchanged and preserve order.
REQ-024 Full FIFO: cmd_ready low; no command SHALL be lost or overwritten; a pop does not re-raise cmd_ready until the following cycle.
REQ-025 Responses SHALL emerge in acceptance order; no response is dropped while rsp_ready is low.
REQ-026 ALU opcodes SHALL pass unmodified: 0000 add, 0001 sub, 0010 and, 0011 or; other codes forwarded as-is.
REQ-027 Arithmetic wraps modulo 2^WIDTH; rsp_zero reflects the ALU zero output, not recomputed.

Reset
REQ-028 rst_n low SHALL asynchronously force: FSM IDLE, FIFO empty, tag counter 0, rsp_valid 0, rsp_result/rsp_remainder/rsp_zero/rsp_tag 0, busy 0.
REQ-029 cmd_ready SHALL be 0 while rst_n low and 1 on the first cycle after release.
REQ-030 Reset mid-operation SHALL discard queued and in-flight commands with no response produced.

Structure
REQ-031 Shared package alu_pkg SHALL hold opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR) and the FSM state enum.
REQ-032 Sub-module: the existing ALU instantiated with WIDTH passed through; FIFO implemented inline.

Verification
REQ-033 Reset then single cmd op=0000 a=15 b=10 -> rsp_valid two cycles after accept, rsp_result=25, rsp_zero=0, rsp_tag=0.
REQ-034 Back-to-back sub(20,10), and(12,10), or(12,10) with rsp_ready=1 -> results 10, 8, 14 in order, tags 0,1,2.
REQ-035 rsp_ready=0, push 5 commands -> cmd_ready low after 4 accepted in FIFO plus 1 in response regs; release rsp_ready -> all 5 responses in order.
REQ-036 add(0,0) -> rsp_result=0, rsp_zero=1; add(16'hFFFF,1) -> rsp_result=0, rsp_zero=1.
REQ-037 17 commands -> rsp_tag sequence 0..15,0.
REQ-038 Assert rst_n low during EXEC with 2 queued -> rsp_valid=0 immediately, no responses after release, next command tag=0.
